fma_result_packer: RTL and testbench

- Back end of the VFPU single-precision fused multiply-add path. The special-case handler classifies the operands; this block takes the raw sum and produces the IEEE-754 result word.
- Takes the un-normalized sign/exponent/mantissa from the adder, normalizes it, rounds to nearest-even, detects overflow and underflow, and packs the 32-bit result.
- A valid special-case result bypasses the arithmetic path.
- 2-stage valid/ready pipeline. Sticky exception flags are held until cleared by software.

---
 rtl/fma_result_packer.sv | 206 ++++++++++++++++++++
 tb/tb_fma_result_packer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_result_packer.sv
// FMA back end: normalizes the raw adder sum, rounds to nearest-even and packs an IEEE single.
// Define DENORM_OUT_EN to emit gradual-underflow results for non-flush (nj_mode=0) beats.
module fma_result_packer #(
   parameter int unsigned MW = 48,
   parameter int unsigned EW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          sign,
   input  logic [EW-1:0] exp_in,
   input  logic [MW-1:0] manti_in,
   input  logic          nj_mode,
   input  logic          spec_mask,
   input  logic [31:0]   res_spec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   res,
   output logic [2:0]    flags,
   input  logic          flag_clr,
   output logic [2:0]    sticky_flags
);

   logic               s1_valid_q, s1_valid_d;
   logic [MW-1:0]      s1_norm_q, s1_norm_d;
   logic signed [10:0] s1_e_q, s1_e_d;
   logic               s1_sign_q, s1_sign_d;
   logic               s1_nj_q, s1_nj_d;
   logic               s1_spec_q, s1_spec_d;
   logic [31:0]        s1_rspec_q, s1_rspec_d;

   logic               out_valid_q, out_valid_d;
   logic [31:0]        res_q, res_d;
   logic [2:0]         flags_q, flags_d;
   logic [2:0]         sticky_q, sticky_d;

   logic               out_fire;
   logic               s1_adv;
   logic               in_fire;

   assign out_fire = out_valid_q & out_ready;
   assign s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s1_adv;
   assign in_fire  = in_valid & in_ready;

   // Stage 1: leading-zero count and normalization
   logic [5:0] lzc;

   always_comb begin
      lzc = 6'd48;
      for (int i = 0; i < 48; i++) begin
         if (manti_in[i]) lzc = 6'(47 - i);
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_norm_d  = s1_norm_q;
      s1_e_d     = s1_e_q;
      s1_sign_d  = s1_sign_q;
      s1_nj_d    = s1_nj_q;
      s1_spec_d  = s1_spec_q;
      s1_rspec_d = s1_rspec_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_norm_d  = manti_in << lzc;
         // Biased exponent: exp_in + 1 - lzc + 127
         s1_e_d     = $signed({exp_in[EW-1], exp_in}) + 11'sd128 - $signed({5'd0, lzc});
         s1_sign_d  = sign;
         s1_nj_d    = nj_mode;
         s1_spec_d  = spec_mask;
         s1_rspec_d = res_spec;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2: round-to-nearest-even on the normal path
   logic [22:0]        frac;
   logic [22:0]        frac_r;
   logic               grd;
   logic               stk;
   logic               rnd_inc;
   logic               carry;
   logic signed [10:0] e_r;
   logic               tiny;
   logic               ovf;

   always_comb begin
      frac            = s1_norm_q[46:24];
      grd             = s1_norm_q[23];
      stk             = |s1_norm_q[22:0];
      rnd_inc         = grd & (stk | frac[0]);
      {carry, frac_r} = {1'b0, frac} + {23'd0, rnd_inc};
      e_r             = s1_e_q + $signed({10'd0, carry});
      tiny            = (s1_e_q <= 11'sd0);
      ovf             = (e_r >= 11'sd255);
   end

`ifdef DENORM_OUT_EN
   logic signed [10:0] dn_amt;
   logic [4:0]         dn_sh;
   logic [73:0]        dn_wide;
   logic [23:0]        dn_sig;
   logic [23:0]        dn_r;
   logic               dn_g;
   logic               dn_st;

   // Denormal: shift {1,f} right by 1-E (at most 25); the padding keeps every dropped bit in sticky
   always_comb begin
      dn_amt  = 11'sd1 - s1_e_q;
      dn_sh   = (dn_amt > 11'sd25) ? 5'd25 : dn_amt[4:0];
      dn_wide = {s1_norm_q, 26'd0} >> dn_sh;
      dn_sig  = dn_wide[73:50];
      dn_g    = dn_wide[49];
      dn_st   = |dn_wide[48:0];
      dn_r    = dn_sig + {23'd0, dn_g & (dn_st | dn_sig[0])};
   end
`else
   logic unused_nj;
   assign unused_nj = s1_nj_q;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      flags_d     = flags_q;
      if (s1_adv) begin
         out_valid_d = 1'b1;
         if (s1_spec_q) begin
            res_d   = s1_rspec_q;
            flags_d = 3'b000;
         end else if (!s1_norm_q[47]) begin
            res_d   = {s1_sign_q, 31'd0};
            flags_d = 3'b000;
         end else if (tiny) begin
`ifdef DENORM_OUT_EN
            if (!s1_nj_q) begin
               // A carry into dn_r[23] lands in the exponent field, giving the smallest normal
               res_d   = {s1_sign_q, 7'd0, dn_r};
               flags_d = {1'b0, 1'b1, dn_g | dn_st};
            end else begin
               res_d   = {s1_sign_q, 31'd0};
               flags_d = 3'b011;
            end
`else
            res_d   = {s1_sign_q, 31'd0};
            flags_d = 3'b011;
`endif
         end else if (ovf) begin
            res_d   = {s1_sign_q, 8'hFF, 23'd0};
            flags_d = 3'b101;
         end else begin
            res_d   = {s1_sign_q, e_r[7:0], frac_r};
            flags_d = {2'b00, grd | stk};
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Clear wipes older flags only; the beat handed over this cycle still lands
   always_comb begin
      sticky_d = sticky_q;
      if (out_fire) begin
         sticky_d = (flag_clr ? 3'd0 : sticky_q) | flags_q;
      end else if (flag_clr) begin
         sticky_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_norm_q   <= '0;
         s1_e_q      <= '0;
         s1_sign_q   <= 1'b0;
         s1_nj_q     <= 1'b0;
         s1_spec_q   <= 1'b0;
         s1_rspec_q  <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= '0;
         sticky_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_norm_q   <= s1_norm_d;
         s1_e_q      <= s1_e_d;
         s1_sign_q   <= s1_sign_d;
         s1_nj_q     <= s1_nj_d;
         s1_spec_q   <= s1_spec_d;
         s1_rspec_q  <= s1_rspec_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         sticky_q    <= sticky_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign res          = res_q;
   assign flags        = flags_q;
   assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fma_result_packer.sv
// Bench for fma_result_packer: directed table, hand-written handshake/sticky/reset sequences and
// randomized traffic scored against a value-level rounding model.
module tb_fma_result_packer;

`ifdef DENORM_OUT_EN
   localparam bit DenormEn = 1'b1;
`else
   localparam bit DenormEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        sign;
   logic [9:0]  exp_in;
   logic [47:0] manti_in;
   logic        nj_mode;
   logic        spec_mask;
   logic [31:0] res_spec;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic [2:0]  flags;
   logic        flag_clr;
   logic [2:0]  sticky_flags;

   always #5 clk = ~clk;

   fma_result_packer dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sign         (sign),
      .exp_in       (exp_in),
      .manti_in     (manti_in),
      .nj_mode      (nj_mode),
      .spec_mask    (spec_mask),
      .res_spec     (res_spec),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .res          (res),
      .flags        (flags),
      .flag_clr     (flag_clr),
      .sticky_flags (sticky_flags)
   );

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flags;
   } exp_t;

   typedef struct {
      logic        sg;
      logic [9:0]  ex;
      logic [47:0] m;
      logic        nj;
      logic        sp;
      logic [31:0] rs;
      logic [31:0] res;
      logic [2:0]  flags;
   } vec_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [34:0] mon_r;
   int          checks = 0;
   int          failures = 0;
   int          acc_cnt = 0;
   logic        mon_on = 1'b0;
   logic        use_tbl = 1'b0;
   logic [31:0] tbl_res = '0;
   logic [2:0]  tbl_flags = '0;
   logic [2:0]  exp_sticky = '0;
   vec_t        vec[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Returns {flags, res}; works on the real value m * 2^(ex-46) with integer rounding
   function automatic logic [34:0] ref_model(input logic sg, input logic [9:0] ex,
                                             input logic [47:0] m, input logic nj,
                                             input logic sp, input logic [31:0] rs);
      int p, eu, be, k, n, sh;
      longint unsigned mm, q, rem, half;
      logic up, inx;
      if (sp) return {3'b000, rs};
      if (m == 48'd0) return {3'b000, sg, 31'd0};
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      mm = 64'(m);
      eu = int'($signed(ex)) + p - 46;
      be = eu + 127;
      if (be <= 0) begin
         if (!(DenormEn && !nj)) return {3'b011, sg, 31'd0};
         // value counted in units of 2^-149
         k = int'($signed(ex)) + 103;
         up = 1'b0;
         if (k >= 0) begin
            q = mm << k;
            inx = 1'b0;
         end else begin
            n = -k;
            if (n > 60) begin
               q = 0;
               inx = 1'b1;
            end else begin
               q = mm >> n;
               rem = mm - (q << n);
               half = 64'd1 << (n - 1);
               inx = (rem != 0);
               up = (rem > half) || (rem == half && q[0]);
            end
         end
         q = q + 64'(up);
         return {2'b01, inx, sg, q[30:0]};
      end
      up = 1'b0;
      if (p >= 23) begin
         sh = p - 23;
         q = mm >> sh;
         rem = mm - (q << sh);
         inx = (rem != 0);
         if (sh > 0) begin
            half = 64'd1 << (sh - 1);
            up = (rem > half) || (rem == half && q[0]);
         end
      end else begin
         q = mm << (23 - p);
         inx = 1'b0;
      end
      q = q + 64'(up);
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         be = be + 1;
      end
      if (be >= 255) return {3'b101, sg, 8'hFF, 23'd0};
      return {2'b00, inx, sg, be[7:0], q[22:0]};
   endfunction

   // Scoreboard monitor: inputs and outputs are stable at the falling edge
   always @(negedge clk) begin
      if (mon_on) begin
         check("sticky_track", 32'(sticky_flags), 32'(exp_sticky));
         if (rst) begin
            sb_q.delete();
            exp_sticky = 3'd0;
         end else begin
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_beat", 32'(out_valid), 32'd0);
               end else begin
                  mon_e = sb_q.pop_front();
                  check("res", res, mon_e.res);
                  check("flags", 32'(flags), 32'(mon_e.flags));
                  exp_sticky = (flag_clr ? 3'd0 : exp_sticky) | mon_e.flags;
               end
            end else if (flag_clr) begin
               exp_sticky = 3'd0;
            end
            if (in_valid && in_ready) begin
               acc_cnt++;
               if (use_tbl) begin
                  mon_e.res = tbl_res;
                  mon_e.flags = tbl_flags;
               end else begin
                  mon_r = ref_model(sign, exp_in, manti_in, nj_mode, spec_mask, res_spec);
                  mon_e.res = mon_r[31:0];
                  mon_e.flags = mon_r[34:32];
               end
               sb_q.push_back(mon_e);
            end
         end
      end
   end

   task automatic drive(input logic sg, input logic [9:0] ex, input logic [47:0] m,
                        input logic nj, input logic sp, input logic [31:0] rs);
      sign = sg;
      exp_in = ex;
      manti_in = m;
      nj_mode = nj;
      spec_mask = sp;
      res_spec = rs;
   endtask

   task automatic send(input logic sg, input logic [9:0] ex, input logic [47:0] m,
                       input logic nj, input logic sp, input logic [31:0] rs);
      bit ok;
      ok = 1'b0;
      drive(sg, ex, m, nj, sp, rs);
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (sb_q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int ev;
      logic [63:0] rm;
      bit ok;

      vec[0]  = '{1'b0, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 32'd0, 32'h3F80_0000, 3'b000};
      vec[1]  = '{1'b0, 10'd0,   48'h4000_0040_0000, 1'b0, 1'b0, 32'd0, 32'h3F80_0000, 3'b001};
      vec[2]  = '{1'b0, 10'd0,   48'h4000_00C0_0000, 1'b0, 1'b0, 32'd0, 32'h3F80_0002, 3'b001};
      vec[3]  = '{1'b1, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0, 32'hFF80_0000, 3'b101};
      vec[4]  = '{1'b0, 10'h381, 48'h4000_0000_0000, 1'b1, 1'b0, 32'd0, 32'h0000_0000, 3'b011};
      vec[5]  = '{1'b0, 10'h381, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0,
                  DenormEn ? 32'h0040_0000 : 32'h0000_0000, DenormEn ? 3'b010 : 3'b011};
      vec[6]  = '{1'b0, 10'd3,   48'h4000_0000_0000, 1'b0, 1'b1, 32'h7FC0_0000,
                  32'h7FC0_0000, 3'b000};
      vec[7]  = '{1'b1, 10'd5,   48'h0,              1'b0, 1'b0, 32'd0, 32'h8000_0000, 3'b000};
      vec[8]  = '{1'b0, 10'd0,   48'h8000_0000_0000, 1'b0, 1'b0, 32'd0, 32'h4000_0000, 3'b000};
      vec[9]  = '{1'b0, 10'd46,  48'h0000_0000_0001, 1'b0, 1'b0, 32'd0, 32'h3F80_0000, 3'b000};
      vec[10] = '{1'b0, 10'd0,   48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'h4080_0000, 3'b001};
      vec[11] = '{1'b0, 10'd126, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'h7F80_0000, 3'b101};
      vec[12] = '{1'b0, 10'd126, 48'h8000_0000_0000, 1'b0, 1'b0, 32'd0, 32'h7F00_0000, 3'b000};
      vec[13] = '{1'b0, 10'h381, 48'h8000_0000_0000, 1'b0, 1'b0, 32'd0, 32'h0080_0000, 3'b000};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      flag_clr = 1'b0;
      drive(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1'b1;

      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_res", res, 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_sticky", 32'(sticky_flags), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency: accepted at edge N, out_valid visible after the following edge
      @(posedge clk);
      #1 drive(1'b0, 10'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0);
      in_valid = 1'b1;
      @(negedge clk);
      check("lat_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("lat_stage1_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_stage2_out_valid", 32'(out_valid), 32'd1);
      check("lat_res", res, 32'h3F80_0000);
      drain();

      use_tbl = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tbl_res = vec[i].res;
         tbl_flags = vec[i].flags;
         send(vec[i].sg, vec[i].ex, vec[i].m, vec[i].nj, vec[i].sp, vec[i].rs);
         drain();
      end
      use_tbl = 1'b0;

      // Sticky flags: overflow sets {1,0,1}; clear coinciding with an inexact beat keeps 001
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("sticky_after_rst", 32'(sticky_flags), 32'd0);
      @(posedge clk);
      #1 send(1'b1, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0);
      drain();
      check("sticky_ovf", 32'(sticky_flags), 32'b101);
      out_ready = 1'b0;
      send(1'b0, 10'd0, 48'h4000_0040_0000, 1'b0, 1'b0, 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_out_valid_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      flag_clr = 1'b1;
      @(posedge clk);
      #1 flag_clr = 1'b0;
      @(negedge clk);
      check("sticky_clr_with_inexact", 32'(sticky_flags), 32'b001);
      drain();

      // Backpressure: three beats offered back to back, two fit
      ev = acc_cnt;
      out_ready = 1'b0;
      drive(1'b0, 10'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0);
      in_valid = 1'b1;
      @(posedge clk);
      #1 drive(1'b0, 10'd0, 48'h4000_00C0_0000, 1'b0, 1'b0, 32'd0);
      @(posedge clk);
      #1 drive(1'b0, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_res_first", res, 32'h3F80_0000);
      repeat (3) @(negedge clk);
      check("bp_res_stable", res, 32'h3F80_0000);
      check("bp_flags_stable", 32'(flags), 32'd0);
      check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
      check("bp_accepted_two", 32'(acc_cnt - ev), 32'd2);
      @(posedge clk);
      #1 out_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("bp_third_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
      check("bp_accepted_three", 32'(acc_cnt - ev), 32'd3);

      // Reset with two beats in flight
      @(posedge clk);
      #1 out_ready = 1'b0;
      drive(1'b0, 10'd0, 48'h4000_00C0_0000, 1'b0, 1'b0, 32'd0);
      in_valid = 1'b1;
      @(posedge clk);
      #1 drive(1'b1, 10'd2, 48'h4000_0000_0000, 1'b0, 1'b0, 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sticky", 32'(sticky_flags), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;

      // Randomized traffic with backpressure and flag clears
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 3) != 0);
         sign = 1'($urandom);
         nj_mode = 1'($urandom);
         spec_mask = ($urandom_range(0, 15) == 0);
         res_spec = $urandom;
         case ($urandom_range(0, 3))
            0: exp_in = 10'($urandom);
            1: exp_in = 10'(int'($urandom_range(0, 240)) - 100);
            2: exp_in = 10'(int'($urandom_range(0, 45)) - 160);
            default: exp_in = 10'(int'($urandom_range(118, 135)));
         endcase
         rm = {$urandom, $urandom};
         manti_in = rm[47:0] >> $urandom_range(0, 47);
         if ($urandom_range(0, 7) == 0) begin
            manti_in = {1'b1, rm[46:24], 1'b1, 23'd0} >> $urandom_range(0, 2);
         end
         if ($urandom_range(0, 15) == 0) manti_in = 48'd0;
         out_ready = ($urandom_range(0, 3) != 0);
         flag_clr = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      flag_clr = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
